// File: rtl/grf_wb_arbiter.sv
// Write-back arbiter: shares the GRF write port between N_REQ sources and registers the winning write.
// Define GRF_ARB_RR_EN for round-robin grants; otherwise the lowest valid index always wins.
module grf_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ*DW-1:0] req_pc,
  output logic                WE,
  output logic [AW-1:0]       A3,
  output logic [DW-1:0]       WD,
  output logic [DW-1:0]       PC,
  output logic                busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]    w_gidx;
  logic [N_REQ-1:0] w_grant;
  logic             w_any;
  logic             w_xfer;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_data;
  logic [DW-1:0]    w_pc;

  logic             r_we;
  logic [AW-1:0]    r_a3;
  logic [DW-1:0]    r_wd;
  logic [DW-1:0]    r_pc;

  assign w_any = |req_valid;

`ifdef GRF_ARB_RR_EN
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;

  // Scan from farthest to nearest so the nearest valid index after ptr is the last write.
  always_comb begin
    w_gidx = '0;
    w_idx  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % N_REQ);
      if (req_valid[w_idx]) w_gidx = w_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_ptr <= PW'(N_REQ - 1);
    else if (w_xfer) r_ptr <= w_gidx;
  end
`else
  always_comb begin
    w_gidx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) w_gidx = PW'(k);
    end
  end
`endif

  assign w_grant   = w_any ? (N_REQ'(1) << w_gidx) : '0;
  assign req_ready = reset ? '0 : w_grant;
  assign w_xfer    = w_any & ~reset;
  assign busy      = w_any & ~(|req_ready);

  assign w_addr = req_addr[int'(w_gidx)*AW +: AW];
  assign w_data = req_data[int'(w_gidx)*DW +: DW];
  assign w_pc   = req_pc[int'(w_gidx)*DW +: DW];

  // Address/data/PC hold across idle cycles; only the write enable returns to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we <= 1'b0;
      r_a3 <= '0;
      r_wd <= '0;
      r_pc <= '0;
    end else begin
      r_we <= w_xfer && (w_addr != '0);
      if (w_xfer) begin
        r_a3 <= w_addr;
        r_wd <= w_data;
        r_pc <= w_pc;
      end
    end
  end

  assign WE = r_we;
  assign A3 = r_a3;
  assign WD = r_wd;
  assign PC = r_pc;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter; expectations follow GRF_ARB_RR_EN when defined.
module tb_grf_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*DW-1:0] req_pc;
  logic            WE;
  logic [AW-1:0]   A3;
  logic [DW-1:0]   WD;
  logic [DW-1:0]   PC;
  logic            busy;

  logic [DW-1:0]   grf [0:(1<<AW)-1];
  int total = 0;
  int bad   = 0;

`ifdef GRF_ARB_RR_EN
  int exp_seq [6] = '{0, 1, 2, 0, 1, 2};
`else
  int exp_seq [6] = '{0, 0, 0, 0, 0, 0};
`endif

  grf_wb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_pc(req_pc),
    .WE(WE), .A3(A3), .WD(WD), .PC(PC), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (WE) grf[A3] <= WD;

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] p);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req_pc[i*DW +: DW]   = p;
  endtask

  task automatic pulse_reset;
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; req_pc = '0;
    #2;
    total++; if (WE !== 1'b0)  begin bad++; $display("FAIL rst_we got=%b exp=0", WE); end
    total++; if (A3 !== '0)    begin bad++; $display("FAIL rst_a3 got=%h exp=0", A3); end
    total++; if (WD !== '0)    begin bad++; $display("FAIL rst_wd got=%h exp=0", WD); end
    total++; if (PC !== '0)    begin bad++; $display("FAIL rst_pc got=%h exp=0", PC); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL rst_ready got=%b exp=000", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy_idle got=%b exp=0", busy); end
    set_req(0, 5'd5, 32'h1234, 32'h3000);
    req_valid = 3'b001;
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy_valid got=%b exp=1", busy); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL rst_ready_valid got=%b exp=000", req_ready); end
  endtask

  task automatic test_single;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL single_ready got=%b exp=001", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    total++; if (WE !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", WE); end
    total++; if (A3 !== 5'd5) begin bad++; $display("FAIL single_a3 got=%h exp=05", A3); end
    total++; if (WD !== 32'h1234) begin bad++; $display("FAIL single_wd got=%h exp=00001234", WD); end
    total++; if (PC !== 32'h3000) begin bad++; $display("FAIL single_pc got=%h exp=00003000", PC); end
    req_valid = '0;
    @(posedge clk); #1;
    total++; if (WE !== 1'b0) begin bad++; $display("FAIL single_we_off got=%b exp=0", WE); end
    total++; if (A3 !== 5'd5) begin bad++; $display("FAIL single_a3_hold got=%h exp=05", A3); end
  endtask

  task automatic test_arbitration;
    logic [N-1:0] exp_rdy;
    pulse_reset;
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), DW'(32'h100 + i), DW'(32'h8000 + i));
    req_valid = 3'b111;
    #1;
    for (int c = 0; c < 6; c++) begin
      exp_rdy = N'(1) << exp_seq[c];
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL arb_ready[%0d] got=%b exp=%b", c, req_ready, exp_rdy); end
      @(posedge clk); #1;
      total++; if (WE !== 1'b1) begin bad++; $display("FAIL arb_we[%0d] got=%b exp=1", c, WE); end
      total++; if (A3 !== AW'(exp_seq[c] + 1)) begin bad++; $display("FAIL arb_a3[%0d] got=%0d exp=%0d", c, A3, exp_seq[c] + 1); end
      total++; if (WD !== DW'(32'h100 + exp_seq[c])) begin bad++; $display("FAIL arb_wd[%0d] got=%h exp=%h", c, WD, 32'h100 + exp_seq[c]); end
    end
    req_valid = '0;
  endtask

  task automatic test_zero_addr;
    set_req(1, 5'd0, 32'hFFFF_FFFF, 32'h4000);
    req_valid = 3'b010;
    #1;
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL zero_ready got=%b exp=010", req_ready); end
    @(posedge clk); #1;
    total++; if (WE !== 1'b0) begin bad++; $display("FAIL zero_we got=%b exp=0", WE); end
    total++; if (A3 !== 5'd0) begin bad++; $display("FAIL zero_a3 got=%h exp=00", A3); end
    total++; if (WD !== 32'hFFFF_FFFF) begin bad++; $display("FAIL zero_wd got=%h exp=ffffffff", WD); end
    req_valid = 3'b111;
    #1;
`ifdef GRF_ARB_RR_EN
    total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL zero_next_ready got=%b exp=100", req_ready); end
`else
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL zero_next_ready got=%b exp=001", req_ready); end
`endif
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic test_collision;
    pulse_reset;
    set_req(0, 5'd7, 32'hA, 32'h10);
    set_req(2, 5'd7, 32'hB, 32'h20);
    req_valid = 3'b101;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL coll_ready0 got=%b exp=001", req_ready); end
    @(posedge clk); #1;
    total++; if (WE !== 1'b1 || A3 !== 5'd7 || WD !== 32'hA) begin bad++; $display("FAIL coll_first got=%b/%0d/%h exp=1/7/a", WE, A3, WD); end
    req_valid = 3'b100;
    #1;
    total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL coll_ready2 got=%b exp=100", req_ready); end
    @(posedge clk); #1;
    total++; if (WE !== 1'b1 || A3 !== 5'd7 || WD !== 32'hB) begin bad++; $display("FAIL coll_second got=%b/%0d/%h exp=1/7/b", WE, A3, WD); end
    total++; if (grf[7] !== 32'hA) begin bad++; $display("FAIL coll_grf_mid got=%h exp=0000000a", grf[7]); end
    req_valid = '0;
    @(posedge clk); #1;
    total++; if (grf[7] !== 32'hB) begin bad++; $display("FAIL coll_grf_final got=%h exp=0000000b", grf[7]); end
  endtask

  task automatic test_reset_mid;
    set_req(0, 5'd9, 32'hC0DE, 32'h5000);
    set_req(1, 5'd10, 32'hBEEF, 32'h5004);
    req_valid = 3'b011;
    @(posedge clk); #1;
    total++; if (WE !== 1'b1 || A3 !== 5'd9) begin bad++; $display("FAIL mid_pre got=%b/%0d exp=1/9", WE, A3); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (WE !== 1'b0) begin bad++; $display("FAIL mid_we got=%b exp=0", WE); end
    total++; if (A3 !== '0 || WD !== '0 || PC !== '0) begin bad++; $display("FAIL mid_regs got=%h/%h/%h exp=0/0/0", A3, WD, PC); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL mid_ready got=%b exp=000", req_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", busy); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL mid_release_ready got=%b exp=001", req_ready); end
    @(posedge clk); #1;
    total++; if (WE !== 1'b1 || A3 !== 5'd9 || WD !== 32'hC0DE) begin bad++; $display("FAIL mid_release_write got=%b/%0d/%h exp=1/9/c0de", WE, A3, WD); end
    req_valid = '0;
  endtask

  task automatic test_starvation;
    int g_cycle;
    int exp_cycle;
    g_cycle = -1;
`ifdef GRF_ARB_RR_EN
    exp_cycle = 1;
`else
    exp_cycle = -1;
`endif
    pulse_reset;
    set_req(0, 5'd1, 32'h111, 32'h0);
    set_req(2, 5'd3, 32'h333, 32'h0);
    req_valid = 3'b101;
    #1;
    for (int c = 0; c < 3; c++) begin
      total++; if (!$onehot(req_ready) || (req_ready & ~req_valid) != '0) begin bad++; $display("FAIL starve_grant[%0d] got=%b exp=onehot_within %b", c, req_ready, req_valid); end
      if (req_ready[2] && g_cycle < 0) g_cycle = c;
      @(posedge clk); #1;
      if (g_cycle >= 0) req_valid[2] = 1'b0;
      #1;
    end
    total++; if (g_cycle != exp_cycle) begin bad++; $display("FAIL starve_req2 got=%0d exp=%0d", g_cycle, exp_cycle); end
    req_valid = '0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_arbitration;
    test_zero_addr;
    test_collision;
    test_reset_mid;
    test_starvation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
